// File: rtl/serial_in.sv
// serial_in: variable-rate serial receiver; 2-FF sync, per-bit window timing from a frequency
// pattern, 3-sample majority vote per bit, one-shot or repeat frame capture.
module serial_in #(
    parameter int DATA_BIT     = 32,
    parameter int LOW_FREQ     = 9,
    parameter int HIGH_FREQ    = 3,
    parameter int START_OFFSET = 4,
    parameter int FRAME_GAP    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic                i_mode,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    input  logic                i_serial_in,
    output logic [DATA_BIT-1:0] o_data,
    output logic                o_glitch,
    output logic                o_bit_tick,
    output logic                o_done_tick,
    output logic                o_busy
);
    localparam int BW = $clog2(DATA_BIT);
    localparam logic [BW-1:0] LAST = BW'(DATA_BIT - 1);
    localparam logic [BW-1:0] ONE = BW'(1);
    localparam logic [7:0] PL = 8'(LOW_FREQ);
    localparam logic [7:0] PH = 8'(HIGH_FREQ);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_RECV, S_GAP} state_t;

    state_t state, state_n;
    logic [1:0] sync;
    logic s_in, mode, mode_n, flag, flag_n, s0, s0_n, s1, s1_n;
    logic glitch_n, bit_tick_n, done_tick_n, vote, agree, accept;
    logic [DATA_BIT-1:0] freq, freq_n, acc, acc_n, data_n;
    logic [7:0] cnt, cnt_n, p, p0, p_nx, off, mid;
    logic [BW-1:0] idx, idx_n, idx_nx;

    assign s_in   = sync[1];
    assign idx_nx = idx + ONE;
    assign p      = freq[idx] ? PH : PL;
    assign p0     = freq[0] ? PH : PL;
    assign p_nx   = freq[idx_nx] ? PH : PL;
    // offset inside the current window and its centre sample
    assign off    = p - 8'd1 - cnt;
    assign mid    = (p - 8'd1) >> 1;
    assign vote   = (s0 & s1) | (s0 & s_in) | (s1 & s_in);
    assign agree  = (s0 == s1) && (s1 == s_in);
    assign accept = i_start && (state == S_IDLE || !i_stop);
    assign o_busy = state != S_IDLE;

    always_comb begin
        state_n     = state;
        mode_n      = mode;
        freq_n      = freq;
        acc_n       = acc;
        flag_n      = flag;
        cnt_n       = cnt;
        idx_n       = idx;
        s0_n        = s0;
        s1_n        = s1;
        data_n      = o_data;
        glitch_n    = o_glitch;
        bit_tick_n  = 1'b0;
        done_tick_n = 1'b0;
        case (state)
            S_LEAD: begin
                cnt_n = cnt - 8'd1;
                if (cnt <= 8'd1) begin
                    state_n = S_RECV;
                    idx_n   = '0;
                    cnt_n   = p0 - 8'd1;
                end
            end
            S_RECV: begin
                if (off == mid - 8'd1) s0_n = s_in;
                if (off == mid) s1_n = s_in;
                if (off == mid + 8'd1) begin
                    acc_n[idx] = vote;
                    flag_n     = flag | !agree;
                    bit_tick_n = 1'b1;
                end
                if (cnt != 8'd0) cnt_n = cnt - 8'd1;
                else if (idx != LAST) begin
                    idx_n = idx_nx;
                    cnt_n = p_nx - 8'd1;
                end else begin
                    // the last bit's decision lands on this same edge, so use acc_n
                    data_n      = acc_n;
                    glitch_n    = flag_n;
                    done_tick_n = 1'b1;
                    state_n     = (mode && FRAME_GAP > 0) ? S_GAP : S_IDLE;
                    cnt_n       = 8'(FRAME_GAP) - 8'd1;
                end
            end
            S_GAP: begin
                cnt_n = cnt - 8'd1;
                if (cnt == 8'd0) begin
                    state_n = S_RECV;
                    idx_n   = '0;
                    cnt_n   = p0 - 8'd1;
                    acc_n   = '0;
                    flag_n  = 1'b0;
                end
            end
            default: ;
        endcase
        if ((state != S_IDLE && i_stop) || accept) begin
            state_n     = S_IDLE;
            bit_tick_n  = 1'b0;
            done_tick_n = 1'b0;
            data_n      = o_data;
            glitch_n    = o_glitch;
        end
        if (accept) begin
            state_n = S_LEAD;
            mode_n  = i_mode;
            freq_n  = i_freq_pattern;
            acc_n   = '0;
            flag_n  = 1'b0;
            cnt_n   = 8'(START_OFFSET - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sync        <= '0;
            mode        <= 1'b0;
            freq        <= '0;
            acc         <= '0;
            flag        <= 1'b0;
            cnt         <= '0;
            idx         <= '0;
            s0          <= 1'b0;
            s1          <= 1'b0;
            o_data      <= '0;
            o_glitch    <= 1'b0;
            o_bit_tick  <= 1'b0;
            o_done_tick <= 1'b0;
        end else begin
            state       <= state_n;
            sync        <= {sync[0], i_serial_in};
            mode        <= mode_n;
            freq        <= freq_n;
            acc         <= acc_n;
            flag        <= flag_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            s0          <= s0_n;
            s1          <= s1_n;
            o_data      <= data_n;
            o_glitch    <= glitch_n;
            o_bit_tick  <= bit_tick_n;
            o_done_tick <= done_tick_n;
        end
    end
endmodule
